// File: rtl/writeback_buffer.sv
// writeback_buffer: four-entry FIFO between execute and register-file write port.
// Results are pushed from execute, written back in arrival order, and pending
// values are forwarded to decode by register number (youngest match wins).
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        synchronous active-low reset
//   resValid   execute offers {resReg, resVal} this cycle
//   resReg     destination register of the offered result
//   resVal     value of the offered result
//   resReady   buffer has a free slot (count < 4)
//   destReg    register-file write address (head entry, 0 when empty)
//   destVal    register-file write data (head entry, 0 when empty)
//   storeNow   register-file write request (buffer not empty)
//   storeDone  register-file acknowledges the current write
//   qryReg     register number looked up by decode
//   qryHit     some pending entry targets qryReg
//   qryVal     value of the youngest pending entry for qryReg, else 0
//   count      number of pending entries, 0..4
module writeback_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        resValid,
    input  logic [3:0]  resReg,
    input  logic [15:0] resVal,
    output logic        resReady,
    output logic [3:0]  destReg,
    output logic [15:0] destVal,
    output logic        storeNow,
    input  logic        storeDone,
    input  logic [3:0]  qryReg,
    output logic        qryHit,
    output logic [15:0] qryVal,
    output logic [2:0]  count
);

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned REG_W = 4;
    localparam int unsigned VAL_W = 16;

    typedef struct packed {
        logic [REG_W-1:0] rnum;
        logic [VAL_W-1:0] val;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [PTR_W-1:0]   idx;
    logic               push;
    logic               pop;

    // Handshake decode; everything here depends on registered state only,
    // so there is no path from resValid or storeDone into resReady/storeNow.
    assign count    = cnt;
    assign resReady = (cnt < CNT_W'(DEPTH));
    assign storeNow = (cnt != '0);
    assign push     = resValid && resReady;
    assign pop      = storeNow && storeDone;
    assign destReg  = storeNow ? mem[rd_ptr].rnum : '0;
    assign destVal  = storeNow ? mem[rd_ptr].val  : '0;

    // Pointers and occupancy; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset: it is only observed for slots below count.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= '{rnum: resReg, val: resVal};
        end
    end

    // Forwarding: walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        qryHit = 1'b0;
        qryVal = '0;
        idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < cnt) && (mem[idx].rnum == qryReg)) begin
                qryHit = 1'b1;
                qryVal = mem[idx].val;
            end
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_writeback_buffer;

    logic        clk;
    logic        rst;
    logic        resValid;
    logic [3:0]  resReg;
    logic [15:0] resVal;
    logic        resReady;
    logic [3:0]  destReg;
    logic [15:0] destVal;
    logic        storeNow;
    logic        storeDone;
    logic [3:0]  qryReg;
    logic        qryHit;
    logic [15:0] qryVal;
    logic [2:0]  count;

    int checks;
    int failures;

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] v;
    } ent_t;

    ent_t mq[$];

    writeback_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .resValid (resValid),
        .resReg   (resReg),
        .resVal   (resVal),
        .resReady (resReady),
        .destReg  (destReg),
        .destVal  (destVal),
        .storeNow (storeNow),
        .storeDone(storeDone),
        .qryReg   (qryReg),
        .qryHit   (qryHit),
        .qryVal   (qryVal),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and apply the same edge to the reference queue.
    task automatic tick();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = resValid && (mq.size() < 4);
        do_pop  = storeDone && (mq.size() != 0);
        e.r = resReg;
        e.v = resVal;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic push_one(input logic [3:0] r, input logic [15:0] v);
        resValid = 1'b1;
        resReg   = r;
        resVal   = v;
        tick();
        resValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; resValid = 1'b0; storeDone = 1'b0; qryReg = 4'd0;
        resReg = '0; resVal = '0;
        tick(); tick();
        rst = 1'b1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (resReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", resReady); end
        checks++; if (storeNow !== 1'b0) begin failures++; $display("FAIL reset_storeNow got=%0b exp=0", storeNow); end
        checks++; if (destReg !== 4'd0 || destVal !== 16'd0) begin failures++; $display("FAIL reset_dest got=%0d/%h exp=0/0000", destReg, destVal); end
        checks++; if (qryHit !== 1'b0 || qryVal !== 16'd0) begin failures++; $display("FAIL reset_qry got=%0b/%h exp=0/0000", qryHit, qryVal); end
    endtask

    task automatic test_single_write();
        storeDone = 1'b0;
        push_one(4'd3, 16'h0100);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) storeDone = 1'b1;
            checks++;
            if (storeNow !== 1'b1 || destReg !== 4'd3 || destVal !== 16'h0100 || count !== 3'd1) begin
                failures++;
                $display("FAIL single_hold cyc=%0d got=%0b/%0d/%h/%0d exp=1/3/0100/1", i, storeNow, destReg, destVal, count);
            end
            if (i < 2) tick();
        end
        tick();
        storeDone = 1'b0;
        checks++; if (storeNow !== 1'b0 || count !== 3'd0 || destVal !== 16'd0) begin failures++; $display("FAIL single_pop got=%0b/%0d/%h exp=0/0/0000", storeNow, count, destVal); end
    endtask

    task automatic test_fill_full();
        storeDone = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(4'(i), 16'h1000 + 16'(i));
        checks++; if (count !== 3'd4 || resReady !== 1'b0) begin failures++; $display("FAIL full_state got=%0d/%0b exp=4/0", count, resReady); end
        push_one(4'd5, 16'hBEEF);
        checks++; if (count !== 3'd4 || destReg !== 4'd1) begin failures++; $display("FAIL full_drop got=%0d/%0d exp=4/1", count, destReg); end
        storeDone = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (storeNow !== 1'b1 || destReg !== 4'(i) || destVal !== 16'h1000 + 16'(i)) begin
                failures++;
                $display("FAIL drain_order i=%0d got=%0b/%0d/%h exp=1/%0d/%h", i, storeNow, destReg, destVal, i, 16'h1000 + 16'(i));
            end
            tick();
        end
        storeDone = 1'b0;
        checks++; if (count !== 3'd0 || storeNow !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%0b exp=0/0", count, storeNow); end
    endtask

    task automatic test_simultaneous();
        storeDone = 1'b0;
        push_one(4'd1, 16'h00A1);
        push_one(4'd2, 16'h00A2);
        resValid = 1'b1; resReg = 4'd6; resVal = 16'h0080; storeDone = 1'b1;
        tick();
        resValid = 1'b0; storeDone = 1'b0;
        checks++; if (count !== 3'd2 || destReg !== 4'd2 || destVal !== 16'h00A2) begin failures++; $display("FAIL simul_count got=%0d/%0d/%h exp=2/2/00a2", count, destReg, destVal); end
        storeDone = 1'b1; tick(); storeDone = 1'b0;
        checks++; if (destReg !== 4'd6 || destVal !== 16'h0080) begin failures++; $display("FAIL simul_next got=%0d/%h exp=6/0080", destReg, destVal); end
        storeDone = 1'b1; tick(); storeDone = 1'b0;
        // Full: a pop does not open a slot for a push in the same cycle.
        for (int i = 1; i <= 4; i++) push_one(4'(i), 16'h2000 + 16'(i));
        resValid = 1'b1; resReg = 4'd9; resVal = 16'h0999; storeDone = 1'b1;
        tick();
        resValid = 1'b0;
        checks++; if (count !== 3'd3 || destReg !== 4'd2) begin failures++; $display("FAIL full_simul got=%0d/%0d exp=3/2", count, destReg); end
        tick(); tick();
        checks++; if (destReg !== 4'd4 || count !== 3'd1) begin failures++; $display("FAIL full_simul_tail got=%0d/%0d exp=4/1", destReg, count); end
        tick();
        storeDone = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_simul_empty got=%0d exp=0", count); end
    endtask

    task automatic test_forwarding();
        storeDone = 1'b0;
        qryReg = 4'd5;
        resValid = 1'b1; resReg = 4'd5; resVal = 16'h0011;
        checks++; if (qryHit !== 1'b0) begin failures++; $display("FAIL fwd_excl got=%0b exp=0", qryHit); end
        tick();
        resValid = 1'b0;
        checks++; if (qryHit !== 1'b1 || qryVal !== 16'h0011) begin failures++; $display("FAIL fwd_one got=%0b/%h exp=1/0011", qryHit, qryVal); end
        push_one(4'd5, 16'h0022);
        checks++; if (qryHit !== 1'b1 || qryVal !== 16'h0022) begin failures++; $display("FAIL fwd_young got=%0b/%h exp=1/0022", qryHit, qryVal); end
        qryReg = 4'd7; #1;
        checks++; if (qryHit !== 1'b0 || qryVal !== 16'h0000) begin failures++; $display("FAIL fwd_miss got=%0b/%h exp=0/0000", qryHit, qryVal); end
        push_one(4'd0, 16'h3333);
        qryReg = 4'd0; #1;
        checks++; if (qryHit !== 1'b1 || qryVal !== 16'h3333) begin failures++; $display("FAIL fwd_r0 got=%0b/%h exp=1/3333", qryHit, qryVal); end
        storeDone = 1'b1; tick(); tick(); tick(); storeDone = 1'b0;
        checks++; if (count !== 3'd0 || qryHit !== 1'b0) begin failures++; $display("FAIL fwd_drain got=%0d/%0b exp=0/0", count, qryHit); end
    endtask

    task automatic test_wrap();
        storeDone = 1'b1;
        for (int i = 0; i < 10; i++) begin
            resValid = 1'b1; resReg = 4'(i); resVal = 16'(i);
            if (i > 0) begin
                checks++;
                if (storeNow !== 1'b1 || destVal !== 16'(i - 1) || destReg !== 4'(i - 1) || count > 3'd4) begin
                    failures++;
                    $display("FAIL wrap i=%0d got=%0b/%0d/%h/%0d exp=1/%0d/%h", i, storeNow, destReg, destVal, count, i - 1, 16'(i - 1));
                end
            end
            tick();
        end
        resValid = 1'b0;
        checks++; if (destVal !== 16'd9 || count !== 3'd1) begin failures++; $display("FAIL wrap_last got=%h/%0d exp=0009/1", destVal, count); end
        tick();
        storeDone = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_empty got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        storeDone = 1'b0;
        push_one(4'd1, 16'h0AAA);
        push_one(4'd2, 16'h0BBB);
        push_one(4'd3, 16'h0CCC);
        checks++; if (count !== 3'd3 || storeNow !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0d/%0b exp=3/1", count, storeNow); end
        rst = 1'b0; storeDone = 1'b1; resValid = 1'b1; resReg = 4'd4; resVal = 16'h0DDD;
        tick();
        rst = 1'b1; resValid = 1'b0; storeDone = 1'b0;
        checks++; if (storeNow !== 1'b0 || count !== 3'd0 || resReady !== 1'b1) begin failures++; $display("FAIL rmid_post got=%0b/%0d/%0b exp=0/0/1", storeNow, count, resReady); end
        storeDone = 1'b1; tick(); storeDone = 1'b0;
        checks++; if (storeNow !== 1'b0 || count !== 3'd0 || destVal !== 16'd0) begin failures++; $display("FAIL rmid_done got=%0b/%0d/%h exp=0/0/0000", storeNow, count, destVal); end
    endtask

    task automatic test_random();
        logic        exp_hit;
        logic [15:0] exp_qv;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) != 0);
            resValid  = ($urandom_range(0, 99) < 60);
            storeDone = ($urandom_range(0, 99) < 45);
            resReg    = 4'($urandom_range(0, 7));
            resVal    = 16'($urandom);
            qryReg    = 4'($urandom_range(0, 7));
            #1;
            exp_hit = 1'b0;
            exp_qv  = '0;
            foreach (mq[k]) begin
                if (mq[k].r == qryReg) begin
                    exp_hit = 1'b1;
                    exp_qv  = mq[k].v;
                end
            end
            checks++;
            if (count !== 3'(mq.size()) || resReady !== (mq.size() < 4) || storeNow !== (mq.size() != 0)) begin
                failures++;
                $display("FAIL rand_ctl cyc=%0d got=%0d/%0b/%0b exp_count=%0d", c, count, resReady, storeNow, mq.size());
            end
            checks++;
            if (destReg !== (mq.size() != 0 ? mq[0].r : 4'd0) || destVal !== (mq.size() != 0 ? mq[0].v : 16'd0)) begin
                failures++;
                $display("FAIL rand_dest cyc=%0d got=%0d/%h", c, destReg, destVal);
            end
            checks++;
            if (qryHit !== exp_hit || qryVal !== exp_qv) begin
                failures++;
                $display("FAIL rand_qry cyc=%0d got=%0b/%h exp=%0b/%h", c, qryHit, qryVal, exp_hit, exp_qv);
            end
            tick();
        end
        rst = 1'b1; resValid = 1'b0; storeDone = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_write();
        test_fill_full();
        test_simultaneous();
        test_forwarding();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low (rst==0 at a rising clk edge resets).
REQ-003 SHALL have port resValid, input, 1 bit: execute stage offers a result this cycle.
REQ-004 SHALL have port resReg, input, 4 bits: destination register of the offered result.
REQ-005 SHALL have port resVal, input, 16 bits: value of the offered result.
REQ-006 SHALL have port resReady, output, 1 bit: buffer can accept a result this cycle.
REQ-007 SHALL have port destReg, output, 4 bits: register file write address (head entry).
REQ-008 SHALL have port destVal, output, 16 bits: register file write data (head entry).
REQ-009 SHALL have port storeNow, output, 1 bit: write request to the register file.
REQ-010 SHALL have port storeDone, input, 1 bit: register file acknowledges the current write.
REQ-011 SHALL have port qryReg, input, 4 bits: register number queried by decode for forwarding.
REQ-012 SHALL have port qryHit, output, 1 bit: a pending entry targets qryReg.
REQ-013 SHALL have port qryVal, output, 16 bits: forwarded value for qryReg.
REQ-014 SHALL have port count, output, 3 bits: number of pending entries, 0..4.

Function
REQ-015 SHALL hold up to 4 entries {reg[3:0], val[15:0]} in FIFO order, using 2-bit read/write pointers that wrap 3->0.
REQ-016 SHALL drive resReady = (count < 4), combinationally from registered state only, independent of storeDone.
REQ-017 SHALL push {resReg, resVal} at a rising edge iff resValid && resReady; resValid while full SHALL be ignored, with no state change.
REQ-018 SHALL drive storeNow = (count != 0), and destReg/destVal = head entry fields; when count==0, destReg=0 and destVal=0.
REQ-019 SHALL pop the head at a rising edge iff storeNow && storeDone; storeDone while storeNow==0 SHALL be ignored.
REQ-020 SHALL keep destReg/destVal stable while storeNow is high until the pop edge.
REQ-021 SHALL give push-to-request latency of 1 cycle: a push into an empty buffer at edge N makes storeNow high from edge N onward; no combinational bypass from resValid to storeNow.
REQ-022 SHALL present the next entry in the cycle after a pop when count > 1; storeNow SHALL remain high with no idle cycle between back-to-back writes.
REQ-023 SHALL apply simultaneous push and pop at one edge both, leaving count unchanged; when full, the pop frees no slot that same cycle because resReady was already 0.
REQ-024 SHALL drive qryHit = 1 iff any pending entry has reg == qryReg; qryVal SHALL be the val of the youngest matching entry, else 0; both combinational from stored state.
REQ-025 SHALL exclude an entry pushed at the current edge from the query until the following cycle.
REQ-026 SHALL apply no special treatment to register 0 entries; they are written and forwarded like any other.
REQ-027 SHALL update count as count + push - pop each edge and never exceed 4 or underflow.

Reset
REQ-028 SHALL, when rst==0 at a rising edge, set count=0 and both pointers=0, which gives storeNow=0, destReg=0, destVal=0, resReady=1, qryHit=0 and qryVal=0 in the following cycle.
REQ-029 SHALL have reset take priority over a simultaneous push or pop; a handshake in progress SHALL be abandoned and its entry discarded.
REQ-030 SHALL need no entry payload reset; stored values SHALL never be visible while count==0.

Verification
REQ-031 SHALL be verified for single write: push {3, 0x0100} into empty buffer, storeDone held 0 for 2 cycles then 1 -> storeNow=1, destReg=3, destVal=0x0100 until pop, then storeNow=0, count=0.
REQ-032 SHALL be verified for fill/full: push regs 1,2,3,4 with storeDone=0 -> count=4, resReady=0; a 5th push {5, 0xBEEF} is dropped; drain -> writes appear in order 1,2,3,4.
REQ-033 SHALL be verified for simultaneous events: count=2 with push {6, 0x0080} and storeDone=1 at one edge -> count stays 2 and the head advances.
REQ-034 SHALL be verified for forwarding: pending {5, 0x0011} then {5, 0x0022}, qryReg=5 -> qryHit=1, qryVal=0x0022; qryReg=7 -> qryHit=0, qryVal=0.
REQ-035 SHALL be verified for wrap-around: 10 push/pop pairs with values 0..9 -> every write is observed in order with correct value and count never exceeds 4.
REQ-036 SHALL be verified for reset mid-handshake: count=3, storeNow=1, rst=0 for one edge -> storeNow=0, count=0, resReady=1, and a later storeDone=1 has no effect.
